// File: rtl/instruction_aligner.sv
// Realigning buffer that turns word-aligned 32-bit fetch words into whole 16/32-bit instructions.
// Compressed-instruction support is compiled in only when ALIGNER_RVC_EN is defined.
module instruction_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_data,
  output logic        fetch_ready,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_word,
  output logic [31:0] inst_pc,
  output logic        inst_compressed
);

  // Handshakes: a word moves when fetch_valid && fetch_ready at a rising edge,
  // an instruction moves when inst_valid && inst_ready; flush discards both.

  logic [15:0] hq [4];
  logic [15:0] hq_nxt [4];
  logic [2:0]  count;
  logic [2:0]  count_nxt;
  logic [2:0]  surv;
  logic [2:0]  push_n;
  logic [1:0]  pop_n;
  logic [31:0] head_pc;
  logic        skip_lo;
  logic        head_c;
  logic        fire;
  logic        push;

`ifdef ALIGNER_RVC_EN
  logic unused_flush_bit;
  assign unused_flush_bit = flush_pc[0];
  assign head_c = (hq[0][1:0] != 2'b11);
`else
  logic [1:0] unused_flush_bits;
  assign unused_flush_bits = flush_pc[1:0];
  assign head_c = 1'b0;
`endif

  // fetch_ready depends only on registered count, never on inst_ready.
  assign fetch_ready = (count <= 3'd2);
  assign inst_valid  = ((count >= 3'd1) && head_c) || (count >= 3'd2);
  assign fire        = inst_valid && inst_ready;
  assign push        = fetch_valid && fetch_ready;
  assign pop_n       = !fire ? 2'd0 : (head_c ? 2'd1 : 2'd2);
  assign push_n      = !push ? 3'd0 : (skip_lo ? 3'd1 : 3'd2);
  assign surv        = count - {1'b0, pop_n};
  assign count_nxt   = surv + push_n;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      hq_nxt[i] = hq[i];
      if (i + int'(pop_n) < 4) hq_nxt[i] = hq[i + int'(pop_n)];
    end
    // New halfwords land directly behind the surviving entries.
    if (push) begin
      for (int i = 0; i < 4; i++) begin
        if (skip_lo) begin
          if (i == int'(surv)) hq_nxt[i] = fetch_data[31:16];
        end else begin
          if (i == int'(surv))     hq_nxt[i] = fetch_data[15:0];
          if (i == int'(surv) + 1) hq_nxt[i] = fetch_data[31:16];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count   <= 3'd0;
      skip_lo <= 1'b0;
      head_pc <= RESET_PC;
      for (int i = 0; i < 4; i++) hq[i] <= 16'h0000;
    end else if (flush) begin
      count <= 3'd0;
`ifdef ALIGNER_RVC_EN
      head_pc <= {flush_pc[31:1], 1'b0};
      skip_lo <= flush_pc[1];
`else
      head_pc <= {flush_pc[31:2], 2'b00};
      skip_lo <= 1'b0;
`endif
    end else begin
      count   <= count_nxt;
      head_pc <= head_pc + {29'd0, pop_n, 1'b0};
      if (push) skip_lo <= 1'b0;
      for (int i = 0; i < 4; i++) hq[i] <= hq_nxt[i];
    end
  end

  always_comb begin
    inst_word = 32'h0;
    if (inst_valid) inst_word = head_c ? {16'h0000, hq[0]} : {hq[1], hq[0]};
  end

  assign inst_compressed = inst_valid && head_c;
  assign inst_pc         = head_pc;

endmodule

// File: tb/tb_instruction_aligner.sv
// Directed bench for instruction_aligner; expectations follow ALIGNER_RVC_EN the same way the design does.
module tb_instruction_aligner;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        fetch_ready;
  logic        flush;
  logic [31:0] flush_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_word;
  logic [31:0] inst_pc;
  logic        inst_compressed;

  int total = 0;
  int bad   = 0;

  instruction_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_ready(fetch_ready),
    .flush(flush), .flush_pc(flush_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_word(inst_word),
    .inst_pc(inst_pc), .inst_compressed(inst_compressed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s failed", tag);
    end
  endtask

  task automatic chk_inst(input string tag, input logic v, input logic [31:0] w,
                          input logic c, input logic [31:0] pc);
    chk({tag, ".valid"}, {31'd0, inst_valid}, {31'd0, v});
    chk({tag, ".word"}, inst_word, w);
    chk({tag, ".comp"}, {31'd0, inst_compressed}, {31'd0, c});
    chk({tag, ".pc"}, inst_pc, pc);
  endtask

  task automatic push_word(input logic [31:0] d);
    fetch_valid = 1'b1;
    fetch_data  = d;
    tick();
    fetch_valid = 1'b0;
  endtask

  task automatic do_flush(input logic [31:0] pc);
    flush    = 1'b1;
    flush_pc = pc;
    tick();
    flush    = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; fetch_valid = 1'b0; fetch_data = 32'h0;
    flush = 1'b0; flush_pc = 32'h0; inst_ready = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    chk_inst("reset", 1'b0, 32'h0, 1'b0, 32'h0);
    chk("reset.fready", {31'd0, fetch_ready}, 32'd1);

`ifdef ALIGNER_RVC_EN
    push_word(32'h00A0_0513);
    chk_inst("t1", 1'b1, 32'h00A0_0513, 1'b0, 32'h0);
    inst_ready = 1'b1; tick();
    chk_inst("t1.pop", 1'b0, 32'h0, 1'b0, 32'h4);

    do_flush(32'h0);
    push_word(32'h4585_4501);
    chk_inst("t2.a", 1'b1, 32'h0000_4501, 1'b1, 32'h0);
    tick();
    chk_inst("t2.b", 1'b1, 32'h0000_4585, 1'b1, 32'h2);
    tick();
    chk_inst("t2.empty", 1'b0, 32'h0, 1'b0, 32'h4);

    do_flush(32'h0);
    push_word(32'h0513_0001);
    chk_inst("t3.a", 1'b1, 32'h0000_0001, 1'b1, 32'h0);
    tick();
    chk_inst("t3.half", 1'b0, 32'h0, 1'b0, 32'h2);
    push_word(32'h0001_00A0);
    chk_inst("t3.straddle", 1'b1, 32'h00A0_0513, 1'b0, 32'h2);
    tick();
    chk_inst("t3.c", 1'b1, 32'h0000_0001, 1'b1, 32'h6);
    tick();
    chk_inst("t3.empty", 1'b0, 32'h0, 1'b0, 32'h8);

    inst_ready = 1'b0;
    push_word(32'h00A0_0513);
    chk("t4.fready1", {31'd0, fetch_ready}, 32'd1);
    push_word(32'h00B0_0593);
    chk("t4.fready2", {31'd0, fetch_ready}, 32'd0);
    chk_inst("t4.held", 1'b1, 32'h00A0_0513, 1'b0, 32'h8);
    push_word(32'hDEAD_BEEF);
    chk_inst("t4.held2", 1'b1, 32'h00A0_0513, 1'b0, 32'h8);
    inst_ready = 1'b1; tick();
    chk_inst("t4.d1", 1'b1, 32'h00B0_0593, 1'b0, 32'hC);
    tick();
    chk_inst("t4.d2", 1'b0, 32'h0, 1'b0, 32'h10);

    inst_ready = 1'b0;
    push_word(32'h0513_0001);
    inst_ready = 1'b1; tick();
    inst_ready = 1'b0;
    push_word(32'h00A0_0001);
    chk("t5.count3", {31'd0, fetch_ready}, 32'd0);
    fetch_valid = 1'b1; fetch_data = 32'hFFFF_FFFF; inst_ready = 1'b1;
    do_flush(32'h0000_0102);
    fetch_valid = 1'b0;
    chk_inst("t5.flush", 1'b0, 32'h0, 1'b0, 32'h102);
    chk("t5.fready", {31'd0, fetch_ready}, 32'd1);
    inst_ready = 1'b0;
    push_word(32'h4585_4501);
    chk_inst("t5.skip", 1'b1, 32'h0000_4585, 1'b1, 32'h102);
    inst_ready = 1'b1; tick();
    chk_inst("t5.empty", 1'b0, 32'h0, 1'b0, 32'h104);

    inst_ready = 1'b0;
    do_flush(32'hFFFF_FFFE);
    push_word(32'h4501_4585);
    chk_inst("t6.top", 1'b1, 32'h0000_4501, 1'b1, 32'hFFFF_FFFE);
    inst_ready = 1'b1; tick();
    chk_inst("t6.wrap", 1'b0, 32'h0, 1'b0, 32'h0);

    inst_ready = 1'b0;
    do_flush(32'h0000_0002);
    push_word(32'h4585_4501);
    push_word(32'h4585_4501);
    chk("t6.count3", {31'd0, fetch_ready}, 32'd0);
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    chk_inst("t6.reset", 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t6.reset.fready", {31'd0, fetch_ready}, 32'd1);
`else
    push_word(32'h00A0_0513);
    chk_inst("t1", 1'b1, 32'h00A0_0513, 1'b0, 32'h0);
    inst_ready = 1'b1; tick();
    chk_inst("t1.pop", 1'b0, 32'h0, 1'b0, 32'h4);

    push_word(32'h4585_4501);
    chk_inst("t2.as32", 1'b1, 32'h4585_4501, 1'b0, 32'h4);
    tick();
    chk_inst("t2.empty", 1'b0, 32'h0, 1'b0, 32'h8);

    inst_ready = 1'b0;
    push_word(32'h00A0_0513);
    chk("t4.fready1", {31'd0, fetch_ready}, 32'd1);
    push_word(32'h00B0_0593);
    chk("t4.fready2", {31'd0, fetch_ready}, 32'd0);
    push_word(32'hDEAD_BEEF);
    chk_inst("t4.held", 1'b1, 32'h00A0_0513, 1'b0, 32'h8);
    inst_ready = 1'b1; tick();
    chk_inst("t4.d1", 1'b1, 32'h00B0_0593, 1'b0, 32'hC);
    tick();
    chk_inst("t4.d2", 1'b0, 32'h0, 1'b0, 32'h10);

    inst_ready = 1'b0;
    push_word(32'h1111_2223);
    fetch_valid = 1'b1; fetch_data = 32'hFFFF_FFFF;
    do_flush(32'h0000_0102);
    fetch_valid = 1'b0;
    chk_inst("t5.flush", 1'b0, 32'h0, 1'b0, 32'h100);
    push_word(32'h4585_4501);
    chk_inst("t5.noskip", 1'b1, 32'h4585_4501, 1'b0, 32'h100);

    do_flush(32'hFFFF_FFFC);
    push_word(32'h0000_0001);
    chk_inst("t6.top", 1'b1, 32'h0000_0001, 1'b0, 32'hFFFF_FFFC);
    inst_ready = 1'b1; tick();
    chk_inst("t6.wrap", 1'b0, 32'h0, 1'b0, 32'h0);

    inst_ready = 1'b0;
    push_word(32'h00A0_0513);
    push_word(32'h00B0_0593);
    chk("t6.full", {31'd0, fetch_ready}, 32'd0);
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    chk_inst("t6.reset", 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t6.reset.fready", {31'd0, fetch_ready}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
